// File: rtl/conv_pkg.sv
// Shared conv types: sequencer state encoding and geometry helpers.
package conv_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } seq_state_e;

    function automatic int kk_f(input int k);
        return k * k;
    endfunction

    function automatic int npix_f(input int d);
        return d * d;
    endfunction

    function automatic int outw_f(input int d, input int k, input int s);
        return (d - k) / s + 1;
    endfunction

    function automatic int nout_f(input int d, input int k, input int s);
        return outw_f(d, k, s) * outw_f(d, k, s);
    endfunction

    localparam int KK_DEF   = kk_f(5);
    localparam int NPIX_DEF = npix_f(32);
    localparam int NOUT_DEF = nout_f(32, 5, 1);
    localparam int X_AW_DEF = $clog2(NPIX_DEF);
    localparam int K_AW_DEF = $clog2(KK_DEF);
    localparam int O_AW_DEF = $clog2(NOUT_DEF);

endpackage

// File: rtl/conv_seq_pipe.sv
// Aligns issued buffer reads with their 1-cycle read data and
// registers the result onto the conv_simple input bus.
module conv_seq_pipe
    import conv_pkg::*;
#(
    parameter int DATA_BW   = 8,
    parameter int WEIGHT_BW = 8,
    parameter int ADDR_BW   = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic                 iss_i,
    input  logic                 wld_i,
    input  logic [ADDR_BW-1:0]   addr_i,
    input  logic [DATA_BW-1:0]   x_i,
    input  logic [WEIGHT_BW-1:0] w_i,
    output logic [DATA_BW-1:0]   cv_x_o,
    output logic [WEIGHT_BW-1:0] cv_w_o,
    output logic [ADDR_BW-1:0]   cv_addr_o,
    output logic                 cv_w_en_o,
    output logic                 cv_valid_o
);

    logic               iss_q;
    logic               wld_q;
    logic [ADDR_BW-1:0] a_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_q      <= 1'b0;
            wld_q      <= 1'b0;
            a_q        <= '0;
            cv_valid_o <= 1'b0;
            cv_w_en_o  <= 1'b0;
            cv_x_o     <= '0;
            cv_w_o     <= '0;
            cv_addr_o  <= '0;
        end else if (flush_i) begin
            iss_q      <= 1'b0;
            wld_q      <= 1'b0;
            a_q        <= '0;
            cv_valid_o <= 1'b0;
            cv_w_en_o  <= 1'b0;
            cv_x_o     <= '0;
            cv_w_o     <= '0;
            cv_addr_o  <= '0;
        end else begin
            iss_q      <= iss_i;
            wld_q      <= iss_i & wld_i;
            a_q        <= addr_i;
            // read data is valid now for the request issued last cycle
            cv_valid_o <= iss_q;
            cv_x_o     <= iss_q ? x_i : '0;
            cv_w_en_o  <= wld_q;
            cv_addr_o  <= wld_q ? a_q : '0;
            cv_w_o     <= wld_q ? w_i : '0;
        end
    end

endmodule

// File: rtl/conv_seq_ctrl.sv
// Runs conv_simple over a stored image for N filters: stream pixels,
// load weights on the first KK pixels, drain results, next filter.
module conv_seq_ctrl
    import conv_pkg::*;
#(
    parameter int KERNEL_SIZE = 5,
    parameter int DATA_SIZE   = 32,
    parameter int STRIDE      = 1,
    parameter int DATA_BW     = 8,
    parameter int WEIGHT_BW   = 8,
    parameter int SUM_BW      = 16,
    parameter int ADDR_BW     = 5,
    parameter int FILT_BW     = 4,
    parameter int DRAIN_TO    = 255,
    localparam int XA_W = $clog2(npix_f(DATA_SIZE)),
    localparam int KA_W = $clog2(kk_f(KERNEL_SIZE)),
    localparam int YO_W = $clog2(nout_f(DATA_SIZE, KERNEL_SIZE, STRIDE)),
    localparam int WA_W = FILT_BW + KA_W,
    localparam int YA_W = FILT_BW + YO_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [FILT_BW-1:0]   i_num_filt,
    output logic                 o_x_rd_en,
    output logic [XA_W-1:0]      o_x_rd_addr,
    input  logic [DATA_BW-1:0]   i_x_rd_data,
    output logic                 o_w_rd_en,
    output logic [WA_W-1:0]      o_w_rd_addr,
    input  logic [WEIGHT_BW-1:0] i_w_rd_data,
    output logic [DATA_BW-1:0]   o_cv_x,
    output logic [WEIGHT_BW-1:0] o_cv_w,
    output logic [ADDR_BW-1:0]   o_cv_addr,
    output logic                 o_cv_w_en,
    output logic                 o_cv_valid,
    input  logic [SUM_BW-1:0]    i_cv_y,
    input  logic                 i_cv_valid,
    output logic                 o_y_wr_en,
    output logic [YA_W-1:0]      o_y_wr_addr,
    output logic [SUM_BW-1:0]    o_y_wr_data,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err
);

    localparam int KK   = kk_f(KERNEL_SIZE);
    localparam int NPIX = npix_f(DATA_SIZE);
    localparam int NOUT = nout_f(DATA_SIZE, KERNEL_SIZE, STRIDE);
    localparam int OC_W = $clog2(NOUT + 1);
    localparam int WD_W = $clog2(DRAIN_TO + 1);

    localparam logic [XA_W-1:0] P_LAST = XA_W'(NPIX - 1);
    localparam logic [XA_W-1:0] P_KK   = XA_W'(KK);
    localparam logic [OC_W-1:0] O_FULL = OC_W'(NOUT);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(DRAIN_TO);
    localparam logic [WA_W-1:0] W_STEP = WA_W'(KK);
    localparam logic [YA_W-1:0] Y_STEP = YA_W'(NOUT);

    seq_state_e         state_q;
    logic [FILT_BW-1:0] nf_q;
    logic [FILT_BW-1:0] filt_q;
    logic [XA_W-1:0]    p_q;
    logic [OC_W-1:0]    out_q;
    logic [WD_W-1:0]    wd_q;
    logic [WA_W-1:0]    wbase_q;
    logic [YA_W-1:0]    ybase_q;

    logic streaming;
    logic w_ld;
    logic out_full;
    logic last_filt;
    logic cap;

    assign streaming = (state_q == S_STREAM);
    assign w_ld      = streaming && (p_q < P_KK);
    assign out_full  = (out_q == O_FULL);
    assign last_filt = (({1'b0, filt_q} + 1'b1) == {1'b0, nf_q});
    assign cap       = i_cv_valid && (state_q != S_IDLE) && !out_full;

    assign o_x_rd_en   = streaming;
    assign o_x_rd_addr = p_q;
    assign o_w_rd_en   = w_ld;
    assign o_w_rd_addr = w_ld ? (wbase_q + WA_W'(p_q)) : '0;
    assign o_busy      = streaming || (state_q == S_DRAIN);

    conv_seq_pipe #(
        .DATA_BW   (DATA_BW),
        .WEIGHT_BW (WEIGHT_BW),
        .ADDR_BW   (ADDR_BW)
    ) u_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (i_abort),
        .iss_i      (streaming),
        .wld_i      (w_ld),
        .addr_i     (ADDR_BW'(p_q)),
        .x_i        (i_x_rd_data),
        .w_i        (i_w_rd_data),
        .cv_x_o     (o_cv_x),
        .cv_w_o     (o_cv_w),
        .cv_addr_o  (o_cv_addr),
        .cv_w_en_o  (o_cv_w_en),
        .cv_valid_o (o_cv_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            nf_q        <= '0;
            filt_q      <= '0;
            p_q         <= '0;
            out_q       <= '0;
            wd_q        <= '0;
            wbase_q     <= '0;
            ybase_q     <= '0;
            o_y_wr_en   <= 1'b0;
            o_y_wr_addr <= '0;
            o_y_wr_data <= '0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_done    <= 1'b0;
            o_y_wr_en <= 1'b0;
            if (i_abort) begin
                state_q <= S_IDLE;
            end else begin
                if (cap) begin
                    o_y_wr_en   <= 1'b1;
                    o_y_wr_addr <= ybase_q + YA_W'(out_q);
                    o_y_wr_data <= i_cv_y;
                    out_q       <= out_q + 1'b1;
                end
                unique case (state_q)
                    S_IDLE: begin
                        if (i_start) begin
                            nf_q    <= i_num_filt;
                            filt_q  <= '0;
                            p_q     <= '0;
                            out_q   <= '0;
                            wd_q    <= '0;
                            wbase_q <= '0;
                            ybase_q <= '0;
                            o_err   <= 1'b0;
                            state_q <= (i_num_filt == '0) ? S_DONE : S_STREAM;
                        end
                    end
                    S_STREAM: begin
                        if (p_q == P_LAST) begin
                            p_q     <= '0;
                            wd_q    <= '0;
                            state_q <= S_DRAIN;
                        end else begin
                            p_q <= p_q + 1'b1;
                        end
                    end
                    S_DRAIN: begin
                        if (out_full) begin
                            if (last_filt) begin
                                state_q <= S_DONE;
                            end else begin
                                filt_q  <= filt_q + 1'b1;
                                wbase_q <= wbase_q + W_STEP;
                                ybase_q <= ybase_q + Y_STEP;
                                p_q     <= '0;
                                out_q   <= '0;
                                wd_q    <= '0;
                                state_q <= S_STREAM;
                            end
                        end else if (wd_q == WD_MAX) begin
                            o_err   <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            wd_q <= wd_q + 1'b1;
                        end
                    end
                    S_DONE: begin
                        o_done  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl with buffer models and a sliding-window conv model.
module tb_conv_seq_ctrl;
    import conv_pkg::*;

    localparam int DTO = 255;

    typedef struct {
        int nf;
        int lim;
        bit extra;
        bit poke;
        int x;
        int w;
        int wr;
        bit err;
        int lat;
    } row_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic [3:0]  i_num_filt = '0;
    logic        o_x_rd_en;
    logic [9:0]  o_x_rd_addr;
    logic [7:0]  x_rd = '0;
    logic        o_w_rd_en;
    logic [8:0]  o_w_rd_addr;
    logic [7:0]  w_rd = '0;
    logic [7:0]  o_cv_x;
    logic [7:0]  o_cv_w;
    logic [4:0]  o_cv_addr;
    logic        o_cv_w_en;
    logic        o_cv_valid;
    logic [15:0] my = '0;
    logic        mv = 1'b0;
    logic        fv = 1'b0;
    logic        i_cv_valid;
    logic        o_y_wr_en;
    logic [13:0] o_y_wr_addr;
    logic [15:0] o_y_wr_data;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    always #5 clk = ~clk;
    assign i_cv_valid = mv | fv;

    conv_seq_ctrl #(.DRAIN_TO(DTO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_abort     (i_abort),
        .i_num_filt  (i_num_filt),
        .o_x_rd_en   (o_x_rd_en),
        .o_x_rd_addr (o_x_rd_addr),
        .i_x_rd_data (x_rd),
        .o_w_rd_en   (o_w_rd_en),
        .o_w_rd_addr (o_w_rd_addr),
        .i_w_rd_data (w_rd),
        .o_cv_x      (o_cv_x),
        .o_cv_w      (o_cv_w),
        .o_cv_addr   (o_cv_addr),
        .o_cv_w_en   (o_cv_w_en),
        .o_cv_valid  (o_cv_valid),
        .i_cv_y      (my),
        .i_cv_valid  (i_cv_valid),
        .o_y_wr_en   (o_y_wr_en),
        .o_y_wr_addr (o_y_wr_addr),
        .o_y_wr_data (o_y_wr_data),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 20)
                $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int img(input int a);
        return (a * 7 + 3) % 256;
    endfunction

    function automatic int wt(input int a);
        return (a * 13 + 5) % 256;
    endfunction

    always @(posedge clk) begin
        if (o_x_rd_en) x_rd <= 8'(img(int'(o_x_rd_addr)));
        if (o_w_rd_en) w_rd <= 8'(wt(int'(o_w_rd_addr)));
    end

    // conv model: emits each output the cycle after its last window pixel
    int          cyc = 0;
    bit          clr = 1'b0;
    int          lim = 784;
    bit          extra = 1'b0;
    bit          pend = 1'b0;
    int          pcnt = 0;
    int          ecnt = 0;
    int          mr, mc, ms;
    int          pix [1024];
    int          wm [25];
    logic [15:0] yq [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        mv <= 1'b0;
        if (clr) begin
            pcnt = 0;
            ecnt = 0;
            pend = 1'b0;
            yq.delete();
        end else begin
            if (o_cv_w_en) wm[o_cv_addr] = int'(o_cv_w);
            if (o_cv_valid) begin
                pix[pcnt] = int'(o_cv_x);
                mr = pcnt / 32;
                mc = pcnt % 32;
                if (mr >= 4 && mc >= 4 && ecnt < lim) begin
                    ms = 0;
                    for (int i = 0; i < 5; i++)
                        for (int j = 0; j < 5; j++)
                            ms += pix[(mr-4+i)*32 + mc-4+j] * wm[i*5+j];
                    mv <= 1'b1;
                    my <= 16'(ms);
                    yq.push_back(16'(ms));
                    ecnt++;
                end
                pcnt++;
                if (pcnt == 1024) begin
                    pcnt = 0;
                    ecnt = 0;
                    pend = extra;
                end
            end else if (pend) begin
                pend = 1'b0;
                mv <= 1'b1;
                my <= 16'hDEAD;
            end
        end
    end

    int          xcnt = 0, wcnt = 0, cvcnt = 0, wrcnt = 0, last_x = 0;
    int          ci, cf;
    logic [15:0] ye;

    always @(negedge clk) begin
        if (clr) begin
            xcnt = 0;
            wcnt = 0;
            cvcnt = 0;
            wrcnt = 0;
        end else begin
            if (o_x_rd_en) begin
                chk("x_addr", int'(o_x_rd_addr), xcnt % 1024);
                xcnt++;
                last_x = cyc;
            end
            if (o_w_rd_en) begin
                chk("w_addr", int'(o_w_rd_addr), wcnt);
                wcnt++;
            end
            if (o_cv_valid) begin
                ci = cvcnt % 1024;
                cf = cvcnt / 1024;
                chk("cv_x", int'(o_cv_x), img(ci));
                chk("cv_w_en", int'(o_cv_w_en), int'(ci < 25));
                if (ci < 25) begin
                    chk("cv_addr", int'(o_cv_addr), ci);
                    chk("cv_w", int'(o_cv_w), wt(cf * 25 + ci));
                end
                cvcnt++;
            end
            if (o_y_wr_en) begin
                chk("y_pending", int'(yq.size() > 0), 1);
                if (yq.size() > 0) begin
                    ye = yq.pop_front();
                    chk("y_addr", int'(o_y_wr_addr), wrcnt);
                    chk("y_data", int'(o_y_wr_data), int'(ye));
                end
                wrcnt++;
            end
        end
    end

    task automatic clear();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic run_row(input row_t r);
        int  gap, lat, dcyc, xd;
        bit  seen, pd;
        lim = r.lim;
        extra = r.extra;
        clear();
        i_num_filt = 4'(r.nf);
        i_start = 1'b1;
        gap = 0; lat = 0; dcyc = 0; seen = 0; pd = 0;
        for (int k = 1; k <= 20000; k++) begin
            @(negedge clk);
            i_start = 1'b0;
            if (k == 1) chk("err_clr", int'(o_err), 0);
            if (o_done) begin
                seen = 1'b1;
                lat = k;
                dcyc = cyc;
                break;
            end
            if (!o_busy) gap++;
            if (r.poke && (k == 300 ||
                (k > 300 && o_busy && !o_x_rd_en && !pd))) begin
                if (k > 300) pd = 1'b1;
                i_start = 1'b1;
                i_num_filt = 4'd3;
            end
        end
        i_start = 1'b0;
        chk("done_seen", int'(seen), 1);
        xd = 0;
        repeat (8) begin
            @(negedge clk);
            if (o_done) xd++;
        end
        chk("x_reads", xcnt, r.x);
        chk("w_reads", wcnt, r.w);
        chk("cv_valids", cvcnt, r.x);
        chk("y_writes", wrcnt, r.wr);
        chk("done_once", xd, 0);
        chk("idle_gap", gap, 1);
        chk("err", int'(o_err), int'(r.err));
        if (r.lat != 0) chk("done_lat", lat, r.lat);
        if (r.err)
            chk("wd_window", int'((dcyc - last_x >= DTO) &&
                                  (dcyc - last_x <= DTO + 4)), 1);
    endtask

    row_t tbl [6];
    int   hits, dn;
    bit   found;

    initial begin
        tbl[0] = '{0, 784, 1'b0, 1'b0,    0,   0,    0, 1'b0, 2};
        tbl[1] = '{1, 784, 1'b0, 1'b0, 1024,  25,  784, 1'b0, 0};
        tbl[2] = '{6, 784, 1'b0, 1'b0, 6144, 150, 4704, 1'b0, 0};
        tbl[3] = '{1, 700, 1'b0, 1'b0, 1024,  25,  700, 1'b1, 0};
        tbl[4] = '{2, 784, 1'b1, 1'b0, 2048,  50, 1568, 1'b0, 0};
        tbl[5] = '{6, 784, 1'b0, 1'b1, 6144, 150, 4704, 1'b0, 0};

        repeat (3) @(negedge clk);
        chk("rst_flags", int'({o_x_rd_en, o_w_rd_en, o_cv_w_en, o_cv_valid,
                               o_y_wr_en, o_busy, o_done, o_err}), 0);
        chk("rst_addr", int'({o_x_rd_addr, o_w_rd_addr, o_cv_addr}), 0);
        chk("rst_data", int'({o_cv_x, o_cv_w, o_y_wr_data}), 0);
        chk("rst_yaddr", int'(o_y_wr_addr), 0);
        rst_n = 1'b1;

        clear();
        fv = 1'b1;
        repeat (3) @(negedge clk);
        fv = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_cv", wrcnt, 0);

        for (int i = 0; i < 5; i++) run_row(tbl[i]);

        lim = 784;
        extra = 1'b0;
        clear();
        i_num_filt = 4'd6;
        i_start = 1'b1;
        hits = 0;
        found = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            i_start = 1'b0;
            if (o_x_rd_en && o_x_rd_addr == 10'd500) begin
                hits++;
                if (hits == 3) begin
                    found = 1'b1;
                    break;
                end
            end
        end
        i_start = 1'b0;
        chk("ab_reach", int'(found), 1);
        chk("ab_filt2", wcnt, 75);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        chk("ab_quiet", int'({o_x_rd_en, o_w_rd_en, o_cv_valid, o_cv_w_en,
                              o_y_wr_en, o_busy, o_done}), 0);
        dn = 0;
        repeat (10) begin
            @(negedge clk);
            if (o_done) dn++;
        end
        chk("ab_nodone", dn, 0);

        run_row(tbl[1]);
        run_row(tbl[5]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_seq_ctrl.md
Name: conv_seq_ctrl

Overview:
Sequencer that runs conv_simple over a stored image for N filters without testbench help. Per filter it streams all DATA_SIZE² pixels from an image buffer. During the first KERNEL_SIZE² pixels it also loads that filter's weights from a weight buffer. It then drains conv outputs into a result buffer and moves to the next filter. Sits between the AXI-side buffers (image, weight, result RAMs) and the conv_simple datapath.

Parameters:
KERNEL_SIZE, 5, kernel edge length
DATA_SIZE, 32, image edge length
STRIDE, 1, conv stride (must match conv_simple)
DATA_BW, 8, pixel width
WEIGHT_BW, 8, weight width
SUM_BW, 16, conv result width
ADDR_BW, 5, conv_simple weight address width
FILT_BW, 4, width of filter count (max 2^FILT_BW-1 filters)
DRAIN_TO, 255, drain watchdog limit in cycles

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_start  in  1  one-cycle start pulse, sampled only in IDLE
i_abort  in  1  synchronous abort, returns to IDLE
i_num_filt  in  FILT_BW  filter count, latched at start
o_x_rd_en  out  1  image buffer read enable
o_x_rd_addr  out  $clog2(DATA_SIZE²)  pixel index
i_x_rd_data  in  DATA_BW  pixel, valid 1 cycle after rd_en
o_w_rd_en  out  1  weight buffer read enable
o_w_rd_addr  out  FILT_BW+$clog2(KERNEL_SIZE²)  filt*KK+k
i_w_rd_data  in  WEIGHT_BW  weight, valid 1 cycle after rd_en
o_cv_x  out  DATA_BW  to conv_simple i_x
o_cv_w  out  WEIGHT_BW  to conv_simple i_w
o_cv_addr  out  ADDR_BW  to conv_simple i_addr
o_cv_w_en  out  1  to conv_simple i_w_en
o_cv_valid  out  1  to conv_simple i_valid
i_cv_y  in  SUM_BW  from conv_simple o_y
i_cv_valid  in  1  from conv_simple o_valid
o_y_wr_en  out  1  result buffer write enable
o_y_wr_addr  out  FILT_BW+$clog2(NOUT)  filt*NOUT+n
o_y_wr_data  out  SUM_BW  result
o_busy  out  1  high outside IDLE/DONE
o_done  out  1  one-cycle pulse on normal or watchdog completion
o_err  out  1  sticky watchdog flag, cleared on accepted start

Behaviour:
- Derived: KK=KERNEL_SIZE², NPIX=DATA_SIZE², OUTW=(DATA_SIZE-KERNEL_SIZE)/STRIDE+1, NOUT=OUTW² (defaults: 25, 1024, 784).
- Reset: all outputs 0; state IDLE; counters 0.
- States: IDLE, STREAM, DRAIN, DONE.
- IDLE: on i_start, latch i_num_filt, clear filt/pixel/out counters and o_err. If i_num_filt==0, go to DONE; else go to STREAM.
- STREAM, cycle p=0..NPIX-1:
  - o_x_rd_en=1, o_x_rd_addr=p.
  - If p<KK: o_w_rd_en=1, o_w_rd_addr=filt*KK+p.
  - One cycle later (registered pipeline stage): o_cv_valid=1, o_cv_x=i_x_rd_data.
  - If the delayed p<KK: o_cv_w_en=1, o_cv_addr=p, o_cv_w=i_w_rd_data; otherwise o_cv_w_en=0, o_cv_addr=0, o_cv_w=0.
  - After p=NPIX-1 is issued, go to DRAIN. The pipeline stage still emits the last pixel.
- DRAIN:
  - o_cv_valid=0 once the pipeline is empty.
  - Watchdog counts up from 0.
  - When out counter reaches NOUT: if filt==num_filt-1, go to DONE; else filt++, p=0, out counter=0, watchdog=0, go to STREAM. There are no bubble cycles other than the 1-cycle pipeline.
  - If watchdog reaches DRAIN_TO first: o_err=1, go to DONE.
- Result capture, all states except IDLE:
  - Each i_cv_valid gives o_y_wr_en=1, o_y_wr_data=i_cv_y, o_y_wr_addr=filt*NOUT+out, then out++. Output is registered (1-cycle latency).
  - i_cv_valid beyond NOUT in a pass is dropped (no write).
  - i_cv_valid in IDLE is ignored.
- DONE: o_done=1 for one cycle, then IDLE.
- i_start while busy: ignored.
- i_abort in any state: the next cycle is IDLE. All enables are 0, o_done is not pulsed, o_err is unchanged.
- i_abort and i_start in the same cycle in IDLE: abort wins.
- Reset mid-operation: immediate return to the reset state. Partial results are left as-is in the buffer.
- Address arithmetic is unsigned and computed with a registered base (filt*KK, filt*NOUT), updated by add on filter advance. There are no multipliers.

Decomposition:
- Shared package conv_pkg holds: the state enum, KK/NPIX/OUTW/NOUT derivation functions, and the clog2-based address width constants. conv_simple and its bench reuse them.
- One sub-module, conv_seq_pipe, holds the 1-cycle read-latency alignment stage from buffer read data to the o_cv_* registers. Everything else stays in conv_seq_ctrl.

Test Plan:
- Filter-count edge case: i_num_filt=0, i_start → o_done the cycle after DONE entry (2 cycles after start), zero reads, zero writes, o_err=0.
- Single filter: i_num_filt=1, behavioural conv model → 1024 x reads, 25 w reads (addr 0..24), o_cv_w_en high on exactly the first 25 o_cv_valid cycles, 784 writes to addr 0..783 matching y golden, one o_done.
- Six filters: i_num_filt=6 → w addrs 0..149, 6144 x reads, 4704 writes to addr 0..4703 in order, o_done once, o_busy continuous.
- Abort: i_abort at filter 2, p=500 → next cycle all enables 0, o_busy=0, no o_done. A following start runs cleanly from filt 0.
- Watchdog: conv model emits only 700 valids → o_err=1 and o_done DRAIN_TO cycles after the last pixel. o_err clears on the next accepted start.
- Start while busy: i_start pulses during STREAM and DRAIN → no restart, counters unaffected, same results as the six-filter case.
